// File: rtl/serial_word_compare_pkg.sv
// Shared types and constants for the serial MSB-first word comparator.
// The result encoding doubles as the {gt, lt} flag pair held by the top.
package serial_word_compare_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef logic [1:0] result_t;

   localparam result_t RES_EQ = 2'b00;
   localparam result_t RES_GT = 2'b10;
   localparam result_t RES_LT = 2'b01;

endpackage

// File: rtl/serial_word_compare_cmp_bit_cell.sv
// Combinational single-bit magnitude cell, reused once per cycle on the
// current MSBs of the two shift registers.
module cmp_bit_cell (
   input  logic a,
   input  logic b,
   output logic eq,
   output logic neq,
   output logic gt,
   output logic lt
);

   assign eq  = ~(a ^ b);
   assign neq = a ^ b;
   assign gt  = a & ~b;
   assign lt  = ~a & b;

endmodule

// File: rtl/serial_word_compare.sv
// Serial unsigned comparator: one bit per cycle MSB-first, fixed WIDTH-cycle
// compare phase, valid/ready handshakes on both sides.
module serial_word_compare
   import serial_word_compare_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             neq,
   output logic             gt,
   output logic             lt
);

   localparam int CW = $clog2(WIDTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   result_t          res_q, res_d;

   logic    cell_eq, cell_neq, cell_gt, cell_lt;
   result_t bit_res;

   cmp_bit_cell u_cell (
      .a   (a_q[WIDTH-1]),
      .b   (b_q[WIDTH-1]),
      .eq  (cell_eq),
      .neq (cell_neq),
      .gt  (cell_gt),
      .lt  (cell_lt)
   );

   assign bit_res = (cell_neq && !cell_eq) ? {cell_gt, cell_lt} : RES_EQ;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
         res_q   <= RES_EQ;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               res_d   = RES_EQ;
               cnt_d   = CW'(WIDTH - 1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // Only the first differing bit decides; later bits cannot override it.
            if (res_q == RES_EQ) begin
               res_d = bit_res;
            end
            a_d = {a_q[WIDTH-2:0], 1'b0};
            b_d = {b_q[WIDTH-2:0], 1'b0};
            if (cnt_q == '0) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign gt        = out_valid && (res_q == RES_GT);
   assign lt        = out_valid && (res_q == RES_LT);
   assign neq       = gt | lt;
   assign eq        = out_valid && !(gt | lt);

endmodule

// File: tb/tb_serial_word_compare.sv
// Scoreboard bench: driver pushes expected flags from integer compares on
// accept; an independent monitor checks every result the DUT presents.
module tb_serial_word_compare;

   localparam int WIDTH = 8;

   typedef struct {
      logic gt;
      logic lt;
      logic eq;
      int   acc_cyc;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a, in_b;
   logic             out_valid;
   logic             out_ready;
   logic             eq, neq, gt, lt;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   stab_checks = 0;
   int   results_seen = 0;
   int   bp_hold = 0;
   bit   rand_bp = 1'b0;
   exp_t sb_q[$];

   serial_word_compare #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .eq        (eq),
      .neq       (neq),
      .gt        (gt),
      .lt        (lt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
      end
   endfunction

   // Consumer backpressure: a directed hold count, otherwise random or always ready.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         if (bp_hold > 0) begin
            out_ready = 1'b0;
            if (out_valid) bp_hold--;
         end else if (rand_bp) begin
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Monitor: protocol invariants plus scoreboard comparison on each handshake.
   initial begin
      logic       prev_valid, prev_ready, prev_hs;
      logic [3:0] prev_flags;
      exp_t       e;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_hs = 1'b0; prev_flags = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_valid = 1'b0; prev_ready = 1'b0; prev_hs = 1'b0;
         end else begin
            if (prev_hs) chk("in_ready_after_handshake", in_ready, 1'b1);
            if (!out_valid) begin
               if ({eq, neq, gt, lt} != 4'b0000)
                  chk("flags_zero_outside_done", {eq, neq, gt, lt}, 4'b0000);
            end else begin
               chk("done_flag_consistency", {eq, neq, gt & lt},
                   {~(gt | lt), gt | lt, 1'b0});
               if (in_ready) chk("in_ready_low_in_done", in_ready, 1'b0);
               if (!prev_valid) begin
                  if (sb_q.size() == 0) begin
                     chk("spurious_out_valid", 1'b1, 1'b0);
                  end else begin
                     chk("latency_edges_after_accept", cyc - sb_q[0].acc_cyc, WIDTH);
                  end
               end else if (!prev_ready) begin
                  stab_checks++;
                  chk("flags_stable_under_backpressure", {eq, neq, gt, lt}, prev_flags);
               end
            end
            prev_hs = out_valid && out_ready;
            if (out_valid && out_ready && sb_q.size() != 0) begin
               e = sb_q.pop_front();
               results_seen++;
               checks++;
               if ({gt, lt, eq, neq} !== {e.gt, e.lt, e.eq, ~e.eq}) begin
                  errors++;
                  $display("FAIL result a=0x%02h b=0x%02h: got gt=%0b lt=%0b eq=%0b neq=%0b, expected gt=%0b lt=%0b eq=%0b neq=%0b",
                           e.a, e.b, gt, lt, eq, neq, e.gt, e.lt, e.eq, ~e.eq);
               end else begin
                  $display("txn a=0x%02h b=0x%02h -> gt=%0b lt=%0b eq=%0b", e.a, e.b, gt, lt, eq);
               end
            end
            prev_valid = out_valid;
            prev_ready = out_ready;
            prev_flags = {eq, neq, gt, lt};
         end
      end
   end

   // Issue a pair, keep in_valid high with churning data during the compare,
   // then wait for the monitor to retire the result.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      exp_t e;
      int   n;
      in_a = a; in_b = b; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      if (!in_ready) begin chk("accept_timeout", 1'b0, 1'b1); in_valid = 1'b0; return; end
      e.gt = (a > b); e.lt = (a < b); e.eq = (a == b);
      e.acc_cyc = cyc + 1; e.a = a; e.b = b;
      sb_q.push_back(e);
      @(negedge clk);
      n = 0;
      while (!out_valid && n < WIDTH + 10) begin
         in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
         @(negedge clk); n++;
      end
      in_valid = 1'b0;
      if (!out_valid) chk("out_valid_timeout", 1'b0, 1'b1);
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
      if (sb_q.size() != 0) begin
         chk("retire_timeout", 1'b0, 1'b1);
         sb_q.delete();
      end
   endtask

   initial begin
      int hs_before;
      logic [WIDTH-1:0] ra, rb;
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
      #1;
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_flags", {eq, neq, gt, lt}, 4'b0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      send(8'h5A, 8'h5A);
      send(8'h80, 8'h7F);
      send(8'h01, 8'h02);
      send(8'hFE, 8'hFF);
      send(8'h00, 8'h00);
      send(8'hFF, 8'h00);

      // Hold the result for 5 cycles of out_ready low.
      bp_hold = 5;
      send(8'h10, 8'h00);
      chk("backpressure_hold_cycles", stab_checks >= 5, 1'b1);

      // Abort in the fourth compare cycle with an asynchronous reset.
      hs_before = results_seen;
      in_a = 8'hC3; in_b = 8'h3C; in_valid = 1'b1;
      while (!in_ready) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("shift_in_ready_low", in_ready, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("async_reset_in_ready", in_ready, 1'b1);
      chk("async_reset_out_valid", out_valid, 1'b0);
      chk("async_reset_flags", {eq, neq, gt, lt}, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (WIDTH + 4) @(negedge clk);
      chk("aborted_no_result", results_seen, hs_before);
      send(8'h03, 8'h03);

      rand_bp = 1'b1;
      for (int i = 0; i < 256; i++) begin
         ra = WIDTH'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : WIDTH'($urandom);
         send(ra, rb);
      end
      rand_bp = 1'b0;
      repeat (4) @(negedge clk);
      chk("all_results_retired", results_seen, 8 + 256);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
